// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared constants for the board input block: how many slide switches and
// push buttons exist, where their words sit in the LSU input region, and the
// default debounce length (10 ms at a 50 MHz clock).
// No ports; imported by io_input_debouncer.
// ---------------------------------------------------------------------------
package io_pkg;

    localparam int unsigned NUM_SW                  = 18;
    localparam int unsigned NUM_KEY                 = 4;

    localparam logic [7:0]  IO_SW_OFFSET            = 8'h00;
    localparam logic [7:0]  IO_BTN_OFFSET           = 8'h10;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// One-bit debouncer: a 2-flop synchronizer, a stability counter and the
// accepted (debounced) level. A new level is accepted only after the
// synchronized input has differed from the current level for
// DEBOUNCE_CYCLES consecutive cycles; any shorter excursion is forgotten.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive differing cycles needed to accept (>= 2)
//   RESET_VAL       - value held by the synchronizer flops during reset
//   INVERT          - invert after synchronization (active-low inputs)
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - asynchronous active-low reset
//   i_raw    - asynchronous raw input level
//   o_level  - debounced level (registered)
//   o_rise   - high in the cycle whose clock edge moves o_level from 0 to 1
// ---------------------------------------------------------------------------
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_VAL       = 1'b0,
    parameter logic        INVERT          = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             synced;
    logic             accept;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; on the last count the level flips and the counter
    // restarts, so it can never pass CNT_MAX or wrap.
    always_comb begin
        sync1_d = i_raw;
        sync2_d = sync1_q;
        synced  = sync2_q ^ INVERT;
        accept  = 1'b0;
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            if (cnt_q == CNT_MAX) begin
                accept  = 1'b1;
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
    // Announced one cycle early so the parent can register the event on the
    // same edge that the level rises.
    assign o_rise  = accept & synced;

endmodule

// File: rtl/io_input_debouncer.sv
// ---------------------------------------------------------------------------
// io_input_debouncer
// Debounces the 18 slide switches and 4 active-low push buttons and keeps a
// sticky press-event bit per button for software to poll and clear.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronized cycles needed to accept a level
// Ports:
//   i_clk        - rising-edge clock
//   i_rst_n      - asynchronous active-low reset
//   i_sw_raw     - raw switch levels, 1 = on
//   i_key_n_raw  - raw button levels, 0 = pressed
//   i_evt_clr    - per-button synchronous clear of the sticky event bits
//   o_io_sw      - {14'b0, debounced switches}   (LSU input offset 0x00)
//   o_io_btn     - {24'b0, evt[3:0], pressed[3:0]} (LSU input offset 0x10)
// ---------------------------------------------------------------------------
module io_input_debouncer
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SW-1:0]  i_sw_raw,
    input  logic [NUM_KEY-1:0] i_key_n_raw,
    input  logic [NUM_KEY-1:0] i_evt_clr,
    output logic [31:0]        o_io_sw,
    output logic [31:0]        o_io_btn
);

    logic [NUM_SW-1:0]  sw_level;
    logic [NUM_SW-1:0]  sw_rise;
    logic [NUM_KEY-1:0] pressed;
    logic [NUM_KEY-1:0] key_rise;
    logic [NUM_KEY-1:0] evt_q, evt_d;
    logic               unused_sw_rise;

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0),
            .INVERT          (1'b0)
        ) u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (i_sw_raw[gi]),
            .o_level (sw_level[gi]),
            .o_rise  (sw_rise[gi])
        );
    end

    // Button synchronizers reset to the released level (1) so leaving reset
    // with the buttons up never looks like a press.
    for (genvar gk = 0; gk < NUM_KEY; gk++) begin : g_key
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b1),
            .INVERT          (1'b1)
        ) u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (i_key_n_raw[gk]),
            .o_level (pressed[gk]),
            .o_rise  (key_rise[gk])
        );
    end

    assign unused_sw_rise = ^sw_rise;

    // A press arriving on the same edge as a clear must not be lost, so the
    // set term is ORed in after the clear is applied.
    always_comb begin
        evt_d = key_rise | (evt_q & ~i_evt_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign o_io_sw  = {{(32 - NUM_SW){1'b0}}, sw_level};
    assign o_io_btn = {{(32 - 2 * NUM_KEY){1'b0}}, evt_q, pressed};

endmodule

// File: tb/tb_io_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_io_input_debouncer
// Drives directed and randomized switch/button activity into the debouncer
// with DEBOUNCE_CYCLES=4 and compares both output words every cycle against
// a behavioural model that accepts a level once the last four synchronized
// samples all disagree with the current level.
// ---------------------------------------------------------------------------
module tb_io_input_debouncer;

    localparam int unsigned DB = 4;
    localparam int          NB = 22;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [17:0] sw_raw    = '0;
    logic [3:0]  key_n_raw = 4'hF;
    logic [3:0]  evt_clr   = '0;
    logic [31:0] io_sw;
    logic [31:0] io_btn;

    int checks = 0;
    int passed = 0;

    // Model state: two synchronizer stages, a window of the last DB
    // synchronized (button-inverted) samples, the accepted levels, events.
    bit          m_s1  [NB];
    bit          m_s2  [NB];
    bit [DB-1:0] m_win [NB];
    bit          m_lvl [NB];
    bit [3:0]    m_evt;

    always #5 clk = ~clk;

    io_input_debouncer #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sw_raw    (sw_raw),
        .i_key_n_raw (key_n_raw),
        .i_evt_clr   (evt_clr),
        .o_io_sw     (io_sw),
        .o_io_btn    (io_btn)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [17:0] sw, input logic [3:0] key_n,
                                 input logic [3:0] clr);
        sw_raw    = sw;
        key_n_raw = key_n;
        evt_clr   = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model reset: switches synchronize 0, buttons synchronize 1 (released).
    task automatic modelReset();
        for (int i = 0; i < NB; i++) begin
            m_s1[i]  = (i >= 18);
            m_s2[i]  = (i >= 18);
            m_win[i] = '0;
            m_lvl[i] = 1'b0;
        end
        m_evt = '0;
    endtask

    task automatic modelStep();
        bit [3:0] rise;
        rise = '0;
        for (int i = 0; i < NB; i++) begin
            bit raw_i;
            bit eff;
            bit want;
            if (i < 18) begin
                raw_i = sw_raw[i];
                eff   = m_s2[i];
            end else begin
                raw_i = key_n_raw[i - 18];
                eff   = ~m_s2[i];
            end
            m_win[i] = {m_win[i][DB-2:0], eff};
            want     = ~m_lvl[i];
            if (m_win[i] == {DB{want}}) begin
                m_lvl[i] = want;
                if (i >= 18 && want) rise[i - 18] = 1'b1;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw_i;
        end
        m_evt = rise | (m_evt & ~evt_clr);
    endtask

    function automatic logic [31:0] expSw();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 18; i++) v[i] = m_lvl[i];
        return v;
    endfunction

    function automatic logic [31:0] expBtn();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v[k]     = m_lvl[18 + k];
            v[4 + k] = m_evt[k];
        end
        return v;
    endfunction

    // Reference model advances on every clock edge and on reset assertion.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else        modelStep();
        end
    end

    // Continuous comparison, well clear of the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            checkOutput("model_sw", io_sw, expSw());
            checkOutput("model_btn", io_btn, expBtn());
        end
    end

    initial begin
        $display("[TB] starting io_input_debouncer bench, DEBOUNCE_CYCLES=%0d", DB);

        // Reset state, then quiet buttons must never raise an event.
        applyStimulus(18'h0, 4'hF, 4'h0);
        tick(3);
        checkOutput("reset_sw", io_sw, 32'h0);
        checkOutput("reset_btn", io_btn, 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            checkOutput("no_evt_after_reset", io_btn, 32'h0);
        end

        // All switches on: visible on edge 6, not edge 5.
        applyStimulus(18'h3FFFF, 4'hF, 4'h0);
        tick(5);
        checkOutput("sw_edge5", io_sw, 32'h0);
        tick(1);
        checkOutput("sw_edge6", io_sw, 32'h0003FFFF);

        // Three-cycle glitch on key 2 is ignored.
        applyStimulus(18'h3FFFF, 4'hB, 4'h0);
        for (int c = 0; c < 3; c++) begin
            tick(1);
            checkOutput("glitch_key2", io_btn, 32'h0);
        end
        applyStimulus(18'h3FFFF, 4'hF, 4'h0);
        for (int c = 0; c < 8; c++) begin
            tick(1);
            checkOutput("glitch_key2", io_btn, 32'h0);
        end

        // Key 0 press, release, then event clear.
        applyStimulus(18'h3FFFF, 4'hE, 4'h0);
        tick(5);
        checkOutput("key0_edge5", io_btn, 32'h0);
        tick(1);
        checkOutput("key0_press", io_btn, 32'h11);
        applyStimulus(18'h3FFFF, 4'hF, 4'h0);
        tick(5);
        checkOutput("key0_rel_edge5", io_btn, 32'h11);
        tick(1);
        checkOutput("key0_release", io_btn, 32'h10);
        applyStimulus(18'h3FFFF, 4'hF, 4'h1);
        tick(1);
        checkOutput("key0_evt_clr", io_btn, 32'h00);
        applyStimulus(18'h3FFFF, 4'hF, 4'h0);

        // Key 1 press while its clear is held: the set wins on that edge.
        applyStimulus(18'h3FFFF, 4'hD, 4'h2);
        tick(6);
        checkOutput("key1_set_wins", io_btn, 32'h22);
        tick(1);
        checkOutput("key1_clr_after", io_btn, 32'h02);
        applyStimulus(18'h3FFFF, 4'hF, 4'h0);
        tick(8);
        checkOutput("key1_released", io_btn, 32'h00);

        // Reset during a switch debounce discards the count.
        applyStimulus(18'h2A5A5, 4'hF, 4'h0);
        tick(1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_sw", io_sw, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        checkOutput("rst_rel_edge5", io_sw, 32'h0);
        tick(1);
        checkOutput("rst_rel_edge6", io_sw, 32'h0002A5A5);

        // Randomized traffic with occasional clears and reset pulses.
        for (int c = 0; c < 500; c++) begin
            logic [17:0] sw_n;
            logic [3:0]  key_n;
            logic [3:0]  clr_n;
            sw_n  = sw_raw;
            key_n = key_n_raw;
            clr_n = '0;
            if ($urandom_range(0, 7) == 0) sw_n = sw_n ^ 18'($urandom);
            if ($urandom_range(0, 5) == 0) key_n = key_n ^ 4'($urandom);
            if ($urandom_range(0, 9) == 0) clr_n = 4'($urandom);
            applyStimulus(sw_n, key_n, clr_n);
            rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        rst_n = 1'b1;
        applyStimulus(sw_raw, key_n_raw, 4'h0);
        tick(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/io_input_debouncer.md
IO_INPUT_DEBOUNCER -- requirements
Module: io_input_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of stable synchronized cycles required to accept a new level (legal range 2..2^20).
REQ-002 The block SHALL have port i_clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port i_sw_raw, input, 18, asynchronous slide-switch levels, 1 = on.
REQ-005 The block SHALL have port i_key_n_raw, input, 4, asynchronous push-button levels, active-low (0 = pressed).
REQ-006 The block SHALL have port i_evt_clr, input, 4, synchronous per-button clear of the sticky press-event bits.
REQ-007 The block SHALL have port o_io_sw, output, 32, debounced switches {14'b0, sw[17:0]}, feeding the LSU input region at offset 0x00.
REQ-008 The block SHALL have port o_io_btn, output, 32, {24'b0, evt[3:0], pressed[3:0]}, feeding the LSU input region at offset 0x10.

Function
REQ-009 Each of the 22 inputs SHALL pass through a 2-flop synchronizer before any other logic; button bits SHALL be inverted after synchronization so that pressed = 1.
REQ-010 Each bit SHALL own an independent counter of width $clog2(DEBOUNCE_CYCLES) and a debounced-level register.
REQ-011 On a cycle where synced != debounced, the counter SHALL increment; on a cycle where synced == debounced, the counter SHALL clear to 0.
REQ-012 When the counter equals DEBOUNCE_CYCLES-1 and synced != debounced, the debounced level SHALL take the synced value on that edge and the counter SHALL clear.
REQ-013 A clean input change held stable SHALL appear on the output exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw level.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave the output unchanged and return the counter to 0.
REQ-015 The counter SHALL never wrap; by REQ-012 it SHALL not exceed DEBOUNCE_CYCLES-1.
REQ-016 evt[i] SHALL set on the edge at which pressed[i] transitions 0->1, and SHALL hold until cleared.
REQ-017 evt[i] SHALL clear on an edge with i_evt_clr[i]=1; if the set and the clear occur on the same edge, the set SHALL win.
REQ-018 Release transitions (pressed 1->0) SHALL NOT affect evt.
REQ-019 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-020 Unused output bits SHALL be constant 0.

Reset
REQ-021 While i_rst_n=0, switch synchronizer flops SHALL be 0 and key synchronizer flops SHALL be 1 (released), so that no false press is generated after reset.
REQ-022 On reset, all counters SHALL be 0 and all debounced switch bits, pressed bits and evt bits SHALL be 0, giving o_io_sw=0 and o_io_btn=0.
REQ-023 Reset asserted mid-debounce SHALL discard the pending count.
REQ-024 After reset release, a switch already on SHALL appear DEBOUNCE_CYCLES+2 edges later.

Structure
REQ-025 Package io_pkg SHALL hold NUM_SW=18, NUM_KEY=4, the IO region offsets (SW 0x00, BTN 0x10) and the default DEBOUNCE_CYCLES.
REQ-026 The block SHALL use one sub-module, debounce_cell: a 1-bit synchronizer, counter and level register, parameterized by DEBOUNCE_CYCLES and reset value, instantiated 22 times via generate.
REQ-027 Edge detection and the evt registers SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset -> o_io_sw=0 and o_io_btn=0 immediately; with i_key_n_raw=4'hF, no evt is set for 20 cycles after release.
REQ-029 i_sw_raw 0 -> 18'h3FFFF held -> o_io_sw=32'h0003FFFF exactly on the 6th edge, and not on the 5th.
REQ-030 i_key_n_raw[2] low for 3 cycles, then high -> o_io_btn stays 0 throughout.
REQ-031 i_key_n_raw[0] held low -> o_io_btn=32'h11 on the 6th edge; after release -> 32'h10; then i_evt_clr[0] pulse -> 32'h00.
REQ-032 i_evt_clr[1]=1 held continuously while key1 press is accepted -> evt[1] reads 1 on the following cycle (set wins).
REQ-033 Assert i_rst_n=0 at edge 2 of a switch debounce, release, hold input -> output updates 6 edges after release, never earlier.
